// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/LSU memory port arbiter.
// Combinational helpers only; no latency.
// No flow control here; constants and the response word selector.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_LSU = 2'd2,
    ARB_FAULT    = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } arb_owner_e;

  // Base of the RAM window; anything below it is an access fault.
  localparam logic [63:0] RAM_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam logic [63:0] ARB_BASE_ADDR = RAM_BASE_ADDR;

  // Pick the 32-bit instruction word out of a 64-bit beat.
  function automatic logic [31:0] word_sel(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, LSU and RAM-side signals of the arbiter.
// Wires only; no latency.
// req/gnt handshakes on both requesters, req/ready toward the RAM.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_fault;

  logic        lsu_req;
  logic        lsu_we;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [63:0] lsu_wmask;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [63:0] lsu_rdata;
  logic        lsu_fault;

  logic        ram_req;
  logic        ram_we;
  logic [63:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic        ram_ready;
  logic        ram_rvalid;
  logic [63:0] ram_rdata;

  // Arbiter side.
  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_fault,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_fault,
    output ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
    input  ram_ready, ram_rvalid, ram_rdata
  );

  // Requesters and RAM side.
  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_fault,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_fault,
    input  ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
    output ram_ready, ram_rvalid, ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_prio_pick.sv
// LSU-priority winner select with IF anti-starvation override.
// Purely combinational; zero latency.
// Next starve count assumes the selected winner is granted this cycle.
module arb_prio_pick #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       if_req_i,
  input  logic       lsu_req_i,
  input  logic [3:0] starve_cnt_i,
  output logic       pick_if_o,
  output logic       pick_lsu_o,
  output logic [3:0] starve_nxt_o
);
  logic starved;

  // LSU wins unless IF has waited through STARVE_MAX LSU grants.
  always_comb begin
    starved    = if_req_i && (starve_cnt_i == 4'(STARVE_MAX));
    pick_lsu_o = lsu_req_i && !starved;
    pick_if_o  = if_req_i && !pick_lsu_o;
    if (pick_if_o)
      starve_nxt_o = 4'd0;
    else if (pick_lsu_o && if_req_i && (starve_cnt_i != 4'(STARVE_MAX)))
      starve_nxt_o = starve_cnt_i + 4'd1;
    else
      starve_nxt_o = starve_cnt_i;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit RAM port between IF and LSU, one transaction in flight; ARB_PERF_CNT_EN adds perf counters.
// Grant same cycle as ram_ready; response one cycle after ram_rvalid; faults answer one cycle after grant.
// Requests stall (ram_req held, no grant) while ram_ready=0; no new grant until the response returns.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [63:0] BASE_ADDR  = ARB_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_lsu_wait,
  output logic [15:0]         perf_force
`endif
);

  arb_state_e  state_q;
  arb_owner_e  owner_q;
  logic [3:0]  starve_q;
  logic        hi_q;
  logic        we_q;
  logic        if_rvalid_q, if_fault_q, lsu_rvalid_q, lsu_fault_q;
  logic [31:0] if_rdata_q;
  logic [63:0] lsu_rdata_q;

  logic        pick_if, pick_lsu;
  logic [3:0]  starve_nxt;
  logic [63:0] sel_addr;
  logic        arb_en, addr_ok, ram_req_c, take;

  arb_prio_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req_i     (bus.if_req),
    .lsu_req_i    (bus.lsu_req),
    .starve_cnt_i (starve_q),
    .pick_if_o    (pick_if),
    .pick_lsu_o   (pick_lsu),
    .starve_nxt_o (starve_nxt)
  );

  // Idle-cycle arbitration: RAM request for legal addresses, immediate take for faults.
  always_comb begin
    sel_addr  = pick_lsu ? bus.lsu_addr : bus.if_addr;
    arb_en    = !rst && (state_q == ARB_IDLE) && (pick_lsu || pick_if);
    addr_ok   = sel_addr >= BASE_ADDR;
    ram_req_c = arb_en && addr_ok;
    take      = arb_en && (!addr_ok || bus.ram_ready);
  end

  assign bus.ram_req   = ram_req_c;
  assign bus.ram_we    = ram_req_c && pick_lsu && bus.lsu_we;
  assign bus.ram_addr  = ram_req_c ? sel_addr : 64'd0;
  assign bus.ram_wdata = (ram_req_c && pick_lsu) ? bus.lsu_wdata : 64'd0;
  assign bus.ram_wmask = (ram_req_c && pick_lsu) ? bus.lsu_wmask : 64'd0;
  assign bus.if_gnt    = take && pick_if;
  assign bus.lsu_gnt   = take && pick_lsu;

  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_fault   = if_fault_q;
  assign bus.lsu_rvalid = lsu_rvalid_q;
  assign bus.lsu_rdata  = lsu_rdata_q;
  assign bus.lsu_fault  = lsu_fault_q;

  // Transaction FSM: latch owner on grant, route the single response, pulse outputs for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      starve_q     <= 4'd0;
      hi_q         <= 1'b0;
      we_q         <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_fault_q   <= 1'b0;
      if_rdata_q   <= 32'd0;
      lsu_rvalid_q <= 1'b0;
      lsu_fault_q  <= 1'b0;
      lsu_rdata_q  <= 64'd0;
    end else begin
      if_rvalid_q  <= 1'b0;
      if_fault_q   <= 1'b0;
      if_rdata_q   <= 32'd0;
      lsu_rvalid_q <= 1'b0;
      lsu_fault_q  <= 1'b0;
      lsu_rdata_q  <= 64'd0;
      case (state_q)
        ARB_IDLE: begin
          if (take) begin
            starve_q <= starve_nxt;
            owner_q  <= pick_lsu ? OWN_LSU : OWN_IF;
            hi_q     <= bus.if_addr[2];
            we_q     <= bus.lsu_we;
            if (!addr_ok) begin
              // Fault response is raised on entry so it is visible during ARB_FAULT.
              state_q      <= ARB_FAULT;
              if_rvalid_q  <= pick_if;
              if_fault_q   <= pick_if;
              lsu_rvalid_q <= pick_lsu;
              lsu_fault_q  <= pick_lsu;
            end else begin
              state_q <= pick_lsu ? ARB_BUSY_LSU : ARB_BUSY_IF;
            end
          end
        end
        ARB_BUSY_IF, ARB_BUSY_LSU: begin
          if (bus.ram_rvalid) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            if (owner_q == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= word_sel(bus.ram_rdata, hi_q);
            end else begin
              lsu_rvalid_q <= 1'b1;
              lsu_rdata_q  <= we_q ? 64'd0 : bus.ram_rdata;
            end
          end
        end
        ARB_FAULT: begin
          state_q <= ARB_IDLE;
          owner_q <= OWN_NONE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait_q, perf_lsu_wait_q;
  logic [15:0] perf_force_q;

  // Saturating wait-cycle and forced-grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_wait_q  <= 32'd0;
      perf_lsu_wait_q <= 32'd0;
      perf_force_q    <= 16'd0;
    end else begin
      if (bus.if_req && !bus.if_gnt && (perf_if_wait_q != '1))
        perf_if_wait_q <= perf_if_wait_q + 32'd1;
      if (bus.lsu_req && !bus.lsu_gnt && (perf_lsu_wait_q != '1))
        perf_lsu_wait_q <= perf_lsu_wait_q + 32'd1;
      if (bus.if_gnt && bus.lsu_req && (perf_force_q != '1))
        perf_force_q <= perf_force_q + 16'd1;
    end
  end

  assign perf_if_wait  = perf_if_wait_q;
  assign perf_lsu_wait = perf_lsu_wait_q;
  assign perf_force    = perf_force_q;
`endif

  // A requester must hold req until it sees gnt.
  a_if_req_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.if_req && !bus.if_gnt) |=> bus.if_req);
  a_lsu_req_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.lsu_req && !bus.lsu_gnt) |=> bus.lsu_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] if_q[$];
  logic [63:0] lsu_q[$];

  mem_port_arbiter_if bus();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait, perf_lsu_wait;
  logic [15:0] perf_force;
`endif

  mem_port_arbiter #(.STARVE_MAX(4), .BASE_ADDR(64'h0000_0000_8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_wait  (perf_if_wait),
    .perf_lsu_wait (perf_lsu_wait),
    .perf_force    (perf_force)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs;
    bus.if_req = 0; bus.if_addr = '0;
    bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    bus.ram_ready = 0; bus.ram_rvalid = 0; bus.ram_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1;
    bus.if_req = 1; bus.if_addr = 64'h8000_0000;
    bus.lsu_req = 1; bus.lsu_addr = 64'h8000_0008;
    bus.ram_ready = 1; bus.ram_rvalid = 1; bus.ram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step;
    @(negedge clk);
    checks++; if ({bus.if_gnt, bus.lsu_gnt, bus.ram_req} !== 3'b000) begin
      failures++; $display("FAIL reset_gnt got=%b exp=000", {bus.if_gnt, bus.lsu_gnt, bus.ram_req}); end
    checks++; if ({bus.if_rvalid, bus.if_fault, bus.lsu_rvalid, bus.lsu_fault} !== 4'b0000) begin
      failures++; $display("FAIL reset_rvalid got=%b exp=0000", {bus.if_rvalid, bus.if_fault, bus.lsu_rvalid, bus.lsu_fault}); end
    checks++; if ({bus.if_rdata, bus.lsu_rdata, bus.ram_addr} !== 160'd0) begin
      failures++; $display("FAIL reset_buses got=%h exp=0", {bus.if_rdata, bus.lsu_rdata, bus.ram_addr}); end
    quiet_inputs();
    step;
    rst = 0;
    step;
  endtask

  task automatic test_if_read;
    logic [31:0] exp;
    bus.if_req = 1; bus.if_addr = 64'h8000_0004; bus.ram_ready = 1;
    @(negedge clk);
    checks++; if ({bus.if_gnt, bus.lsu_gnt, bus.ram_req, bus.ram_we} !== 4'b1010) begin
      failures++; $display("FAIL if_read_gnt got=%b exp=1010", {bus.if_gnt, bus.lsu_gnt, bus.ram_req, bus.ram_we}); end
    checks++; if ({bus.ram_addr, bus.ram_wmask} !== {64'h8000_0004, 64'd0}) begin
      failures++; $display("FAIL if_read_fields got=%h exp=%h", {bus.ram_addr, bus.ram_wmask}, {64'h8000_0004, 64'd0}); end
    if (bus.if_gnt) if_q.push_back(32'hAAAA_BBBB);
    step;
    bus.if_req = 0; bus.ram_rvalid = 1; bus.ram_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    checks++; if ({bus.if_rvalid, bus.ram_req} !== 2'b00) begin
      failures++; $display("FAIL if_read_busy got=%b exp=00", {bus.if_rvalid, bus.ram_req}); end
    step;
    bus.ram_rvalid = 0; bus.ram_rdata = '0;
    @(negedge clk);
    checks++; if ({bus.if_rvalid, bus.if_fault, bus.lsu_rvalid} !== 3'b100) begin
      failures++; $display("FAIL if_read_rvalid got=%b exp=100", {bus.if_rvalid, bus.if_fault, bus.lsu_rvalid}); end
    if (bus.if_rvalid) begin
      exp = (if_q.size() != 0) ? if_q.pop_front() : 32'hDEAD_0000;
      checks++; if (bus.if_rdata !== exp) begin
        failures++; $display("FAIL if_read_data got=%h exp=%h", bus.if_rdata, exp); end
    end
    step;
    @(negedge clk);
    checks++; if ({bus.if_rvalid, bus.if_rdata} !== 33'd0) begin
      failures++; $display("FAIL if_read_after got=%h exp=0", {bus.if_rvalid, bus.if_rdata}); end
    step;
  endtask

  task automatic test_lsu_write;
    logic [63:0] exp;
    bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 64'h8000_0010;
    bus.lsu_wdata = 64'h1122_3344_5566_7788; bus.lsu_wmask = 64'hFF; bus.ram_ready = 1;
    @(negedge clk);
    checks++; if ({bus.lsu_gnt, bus.if_gnt, bus.ram_req, bus.ram_we} !== 4'b1011) begin
      failures++; $display("FAIL lsu_wr_gnt got=%b exp=1011", {bus.lsu_gnt, bus.if_gnt, bus.ram_req, bus.ram_we}); end
    checks++; if ({bus.ram_addr, bus.ram_wdata, bus.ram_wmask} !== {64'h8000_0010, 64'h1122_3344_5566_7788, 64'hFF}) begin
      failures++; $display("FAIL lsu_wr_fields got=%h", {bus.ram_addr, bus.ram_wdata, bus.ram_wmask}); end
    if (bus.lsu_gnt) lsu_q.push_back(64'd0);
    step;
    bus.lsu_req = 0; bus.lsu_we = 0; bus.ram_rvalid = 1; bus.ram_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    checks++; if (bus.lsu_rvalid !== 1'b0) begin
      failures++; $display("FAIL lsu_wr_early got=%b exp=0", bus.lsu_rvalid); end
    step;
    bus.ram_rvalid = 0;
    @(negedge clk);
    checks++; if ({bus.lsu_rvalid, bus.lsu_fault} !== 2'b10) begin
      failures++; $display("FAIL lsu_wr_ack got=%b exp=10", {bus.lsu_rvalid, bus.lsu_fault}); end
    if (bus.lsu_rvalid) begin
      exp = (lsu_q.size() != 0) ? lsu_q.pop_front() : 64'hBAD;
      checks++; if (bus.lsu_rdata !== exp) begin
        failures++; $display("FAIL lsu_wr_rdata got=%h exp=%h", bus.lsu_rdata, exp); end
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [63:0] rd, exp64;
    logic [31:0] exp32;
    logic prev_if, exp_if;
    prev_if = 0;
    bus.if_req = 1; bus.if_addr = 64'h8000_0000;
    bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 64'h8000_0020; bus.ram_ready = 1;
    for (int i = 0; i < 11; i++) begin
      rd = {16'hC0DE, 16'(i), 16'h5EED, 16'(i)};
      exp_if = (i % 5) == 4;
      @(negedge clk);
      if (i > 0) begin
        checks++; if ({bus.if_rvalid, bus.lsu_rvalid} !== (prev_if ? 2'b10 : 2'b01)) begin
          failures++; $display("FAIL b2b_rsp_owner%0d got=%b exp_if=%b", i, {bus.if_rvalid, bus.lsu_rvalid}, prev_if); end
        if (bus.if_rvalid) begin
          exp32 = (if_q.size() != 0) ? if_q.pop_front() : 32'hBAD;
          checks++; if (bus.if_rdata !== exp32) begin
            failures++; $display("FAIL b2b_if_data%0d got=%h exp=%h", i, bus.if_rdata, exp32); end
        end else if (bus.lsu_rvalid) begin
          exp64 = (lsu_q.size() != 0) ? lsu_q.pop_front() : 64'hBAD;
          checks++; if (bus.lsu_rdata !== exp64) begin
            failures++; $display("FAIL b2b_lsu_data%0d got=%h exp=%h", i, bus.lsu_rdata, exp64); end
        end
      end
      checks++; if ({bus.if_gnt, bus.lsu_gnt} !== (exp_if ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL b2b_grant%0d got=%b exp_if=%b", i, {bus.if_gnt, bus.lsu_gnt}, exp_if); end
      if (bus.if_gnt) if_q.push_back(bus.if_addr[2] ? rd[63:32] : rd[31:0]);
      if (bus.lsu_gnt) lsu_q.push_back(rd);
      prev_if = bus.if_gnt;
      step;
      if (i == 4) bus.if_addr = 64'h8000_0004;
      if (i == 9) bus.if_req = 0;
      if (i == 10) bus.lsu_req = 0;
      bus.ram_rvalid = 1; bus.ram_rdata = rd;
      @(negedge clk);
      checks++; if ({bus.if_gnt, bus.lsu_gnt, bus.ram_req} !== 3'b000) begin
        failures++; $display("FAIL b2b_busy%0d got=%b exp=000", i, {bus.if_gnt, bus.lsu_gnt, bus.ram_req}); end
      step;
      bus.ram_rvalid = 0;
    end
    @(negedge clk);
    checks++; if ({bus.if_rvalid, bus.lsu_rvalid} !== 2'b01) begin
      failures++; $display("FAIL b2b_last_rsp got=%b exp=01", {bus.if_rvalid, bus.lsu_rvalid}); end
    exp64 = (lsu_q.size() != 0) ? lsu_q.pop_front() : 64'hBAD;
    checks++; if (bus.lsu_rdata !== exp64) begin
      failures++; $display("FAIL b2b_last_data got=%h exp=%h", bus.lsu_rdata, exp64); end
    step;
  endtask

  task automatic test_fault;
    logic        who [4];
    logic [63:0] addr [4];
    logic        flt [4];
    logic [63:0] got, exp;
    logic        rv, fl;
    who[0] = 1; addr[0] = 64'h0000_1000; flt[0] = 1;
    who[1] = 0; addr[1] = 64'h7FFF_FFFC; flt[1] = 1;
    who[2] = 1; addr[2] = 64'h8000_0000; flt[2] = 0;
    who[3] = 1; addr[3] = 64'h7FFF_FFFF; flt[3] = 1;
    for (int e = 0; e < 4; e++) begin
      bus.ram_ready = 1;
      if (who[e]) begin bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = addr[e]; end
      else begin bus.if_req = 1; bus.if_addr = addr[e]; end
      @(negedge clk);
      checks++; if ({bus.if_gnt, bus.lsu_gnt, bus.ram_req} !== {!who[e], who[e], !flt[e]}) begin
        failures++; $display("FAIL fault_gnt%0d got=%b exp=%b", e, {bus.if_gnt, bus.lsu_gnt, bus.ram_req}, {!who[e], who[e], !flt[e]}); end
      if (who[e]) lsu_q.push_back(flt[e] ? 64'd0 : 64'h0123_4567_89AB_CDEF);
      else if_q.push_back(32'd0);
      step;
      bus.if_req = 0; bus.lsu_req = 0;
      bus.ram_rvalid = !flt[e]; bus.ram_rdata = 64'h0123_4567_89AB_CDEF;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        rv = who[e] ? bus.lsu_rvalid : bus.if_rvalid;
        fl = who[e] ? bus.lsu_fault : bus.if_fault;
        got = who[e] ? bus.lsu_rdata : {32'd0, bus.if_rdata};
        checks++; if ({rv, fl} !== {(c == 0) == flt[e], (c == 0) && flt[e]}) begin
          failures++; $display("FAIL fault_rsp%0d_%0d got=%b exp=%b", e, c, {rv, fl}, {(c == 0) == flt[e], (c == 0) && flt[e]}); end
        if (rv) begin
          if (who[e]) exp = (lsu_q.size() != 0) ? lsu_q.pop_front() : 64'hBAD;
          else exp = (if_q.size() != 0) ? {32'd0, if_q.pop_front()} : 64'hBAD;
          checks++; if (got !== exp) begin
            failures++; $display("FAIL fault_data%0d got=%h exp=%h", e, got, exp); end
        end
        step;
        bus.ram_rvalid = 0;
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 64'h8000_0030; bus.ram_ready = 1;
    @(negedge clk);
    checks++; if (bus.lsu_gnt !== 1'b1) begin
      failures++; $display("FAIL rstmid_gnt got=%b exp=1", bus.lsu_gnt); end
    step;
    bus.lsu_req = 0; rst = 1;
    @(negedge clk);
    checks++; if ({bus.ram_req, bus.lsu_gnt, bus.if_gnt, bus.lsu_rvalid, bus.if_rvalid, bus.lsu_rdata} !== 69'd0) begin
      failures++; $display("FAIL rstmid_outs got=%h exp=0", {bus.ram_req, bus.lsu_gnt, bus.if_gnt, bus.lsu_rvalid, bus.if_rvalid, bus.lsu_rdata}); end
    step;
    rst = 0; bus.ram_rvalid = 1; bus.ram_rdata = 64'h5555_AAAA_5555_AAAA;
    step;
    bus.ram_rvalid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({bus.lsu_rvalid, bus.if_rvalid} !== 2'b00) begin
        failures++; $display("FAIL rstmid_stray%0d got=%b exp=00", c, {bus.lsu_rvalid, bus.if_rvalid}); end
      step;
    end
  endtask

  task automatic test_stall;
    logic [63:0] exp;
    int n;
    bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_addr = 64'h8000_0040; bus.ram_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({bus.lsu_gnt, bus.ram_req, bus.ram_we, bus.ram_addr} !== {3'b010, 64'h8000_0040}) begin
        failures++; $display("FAIL stall%0d got=%h", c, {bus.lsu_gnt, bus.ram_req, bus.ram_we, bus.ram_addr}); end
      step;
    end
    bus.ram_ready = 1;
    @(negedge clk);
    checks++; if (bus.lsu_gnt !== 1'b1) begin
      failures++; $display("FAIL stall_gnt got=%b exp=1", bus.lsu_gnt); end
    if (bus.lsu_gnt) lsu_q.push_back(64'h0F0F_1E1E_2D2D_3C3C);
    step;
    bus.lsu_req = 0; bus.ram_ready = 0;
    step;
    bus.ram_rvalid = 1; bus.ram_rdata = 64'h0F0F_1E1E_2D2D_3C3C;
    step;
    bus.ram_rvalid = 0; bus.ram_rdata = '0;
    n = 0;
    @(negedge clk);
    while (!bus.lsu_rvalid && n < 8) begin n++; @(negedge clk); end
    checks++; if (bus.lsu_rvalid !== 1'b1) begin
      failures++; $display("FAIL stall_rsp_timeout got=%b exp=1", bus.lsu_rvalid); end
    else begin
      exp = (lsu_q.size() != 0) ? lsu_q.pop_front() : 64'hBAD;
      checks++; if (bus.lsu_rdata !== exp) begin
        failures++; $display("FAIL stall_data got=%h exp=%h", bus.lsu_rdata, exp); end
    end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet_inputs();
    rst = 1;
    repeat (2) step;
    test_reset();
    test_if_read();
    test_lsu_write();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
